// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - PMP configuration types, CSR addresses and address read helpers
package ibex_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
    localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
    localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
    localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
    localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
    localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
    localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
    localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
    localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
    localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
    localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
    localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
    localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
    localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
    localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
    localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
    localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
    localparam logic [11:0] CSR_MSECCFG   = 12'h747;
    localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

    // Stored pmpaddr is raw; the granularity view is applied on the way out.
    function automatic logic [31:0] pmp_addr_adjust(input logic [31:0]   addr,
                                                    input pmp_cfg_mode_e mode,
                                                    input int            g);
        logic [31:0] res;
        res = addr;
        if (g == 1) begin
            if (mode != PMP_MODE_NAPOT) begin
                res[0] = 1'b0;
            end
        end else if (g >= 2) begin
            for (int b = 0; b < 32; b++) begin
                if (mode == PMP_MODE_NAPOT) begin
                    if (b <= g - 2) begin
                        res[b] = 1'b1;
                    end
                end else if (b <= g - 1) begin
                    res[b] = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] pmp_cfg_byte(input pmp_cfg_t cfg);
        return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
    endfunction

endpackage

// File: rtl/ibex_pmp_cfg_legalise.sv
// rtl/ibex_pmp_cfg_legalise.sv - per-entry pmpcfg byte legaliser (lock, reserved RW, MML, NA4)
module ibex_pmp_cfg_legalise
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  pmp_cfg_t   cfg_old_i,
    input  logic [7:0] wdata_i,
    input  logic       mml_i,
    input  logic       rlb_i,
    output pmp_cfg_t   cfg_new_o,
    output logic       accept_o
);

    pmp_cfg_t wr_cfg;
    logic     locked;
    logic     reserved_rw;
    logic     mml_block;

    always_comb begin
        wr_cfg       = '0;
        wr_cfg.lock  = wdata_i[7];
        wr_cfg.mode  = pmp_cfg_mode_e'(wdata_i[4:3]);
        wr_cfg.exec  = wdata_i[2];
        wr_cfg.write = wdata_i[1];
        wr_cfg.read  = wdata_i[0];
        // NA4 cannot be represented above 4-byte granularity; keep the previous mode.
        if ((PMPGranularity >= 1) && (wdata_i[4:3] == 2'b10)) begin
            wr_cfg.mode = cfg_old_i.mode;
        end

        locked      = cfg_old_i.lock & ~rlb_i;
        reserved_rw = ~mml_i & ~wdata_i[0] & wdata_i[1];
        mml_block   = mml_i & ~rlb_i & wdata_i[7] & (wdata_i[2] | (~wdata_i[0] & wdata_i[1]));

        accept_o  = ~(locked | reserved_rw | mml_block);
        cfg_new_o = accept_o ? wr_cfg : cfg_old_i;
    end

endmodule

// File: rtl/ibex_pmp_csr.sv
// rtl/ibex_pmp_csr.sv - PMP/Smepmp CSR register file driving the PMP checker
module ibex_pmp_csr
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         csr_we_i,
    input  logic [11:0]  csr_addr_i,
    input  logic [31:0]  csr_wdata_i,
    output logic [31:0]  csr_rdata_o,
    output logic         csr_hit_o,
    output pmp_cfg_t     csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t csr_pmp_mseccfg_o,
    output logic         pmp_flush_o
);

    pmp_cfg_t     cfg_q     [PMPNumRegions];
    pmp_cfg_t     cfg_d     [PMPNumRegions];
    pmp_cfg_t     cfg_legal [PMPNumRegions];
    logic [31:0]  addr_q    [PMPNumRegions];
    logic [31:0]  addr_d    [PMPNumRegions];
    logic [31:0]  addr_rd   [PMPNumRegions];
    pmp_mseccfg_t mseccfg_q, mseccfg_d;
    logic         flush_q, flush_d;

    logic [PMPNumRegions-1:0] cfg_accept;
    logic [PMPNumRegions-1:0] lock_eff;
    logic [PMPNumRegions-1:0] tor_guard;
    logic [PMPNumRegions-1:0] cfg_sel;
    logic [PMPNumRegions-1:0] addr_sel;
    logic                     any_lock;
    logic                     is_cfg, is_addr, is_msec, is_msech, wr_en;

    assign is_cfg    = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
    assign is_addr   = (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
    assign is_msec   = (csr_addr_i == CSR_MSECCFG);
    assign is_msech  = (csr_addr_i == CSR_MSECCFGH);
    assign csr_hit_o = is_cfg | is_addr | is_msec | is_msech;
    assign wr_en     = csr_we_i & csr_hit_o;

    for (genvar i = 0; i < PMPNumRegions; i++) begin : g_legal
        ibex_pmp_cfg_legalise #(
            .PMPGranularity(PMPGranularity)
        ) u_legal (
            .cfg_old_i(cfg_q[i]),
            .wdata_i  (csr_wdata_i[8*(i%4) +: 8]),
            .mml_i    (mseccfg_q.mml),
            .rlb_i    (mseccfg_q.rlb),
            .cfg_new_o(cfg_legal[i]),
            .accept_o (cfg_accept[i])
        );
    end

    always_comb begin
        lock_eff  = '0;
        tor_guard = '0;
        cfg_sel   = '0;
        addr_sel  = '0;
        any_lock  = 1'b0;
        flush_d   = 1'b0;
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            lock_eff[i] = cfg_q[i].lock & ~mseccfg_q.rlb;
            any_lock    = any_lock | cfg_q[i].lock;
        end
        // A locked TOR entry also freezes the pmpaddr that forms its lower bound.
        for (int i = 0; i < int'(PMPNumRegions) - 1; i++) begin
            tor_guard[i] = lock_eff[i+1] & (cfg_q[i+1].mode == PMP_MODE_TOR);
        end
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            cfg_sel[i]  = wr_en & is_cfg & (int'(csr_addr_i[1:0]) == i / 4);
            addr_sel[i] = wr_en & is_addr & (int'(csr_addr_i[3:0]) == i);
            cfg_d[i]    = (cfg_sel[i] & cfg_accept[i]) ? cfg_legal[i] : cfg_q[i];
            addr_d[i]   = (addr_sel[i] & ~lock_eff[i] & ~tor_guard[i]) ? csr_wdata_i : addr_q[i];
            flush_d     = flush_d | (cfg_d[i] != cfg_q[i]) | (addr_d[i] != addr_q[i]);
        end

        mseccfg_d = mseccfg_q;
        if (wr_en & is_msec) begin
            mseccfg_d.mml  = mseccfg_q.mml  | csr_wdata_i[0];
            mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
            if (mseccfg_q.rlb | ~any_lock) begin
                mseccfg_d.rlb = csr_wdata_i[2];
            end
        end
        flush_d = flush_d | (mseccfg_d != mseccfg_q);
    end

    always_comb begin
        csr_rdata_o = '0;
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            addr_rd[i]        = pmp_addr_adjust(addr_q[i], cfg_q[i].mode, int'(PMPGranularity));
            csr_pmp_addr_o[i] = {addr_rd[i], 2'b00};
            csr_pmp_cfg_o[i]  = cfg_q[i];
            if (is_cfg && (int'(csr_addr_i[1:0]) == i / 4)) begin
                csr_rdata_o[8*(i%4) +: 8] = pmp_cfg_byte(cfg_q[i]);
            end
            if (is_addr && (int'(csr_addr_i[3:0]) == i)) begin
                csr_rdata_o = addr_rd[i];
            end
        end
        if (is_msec) begin
            csr_rdata_o = {29'b0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            mseccfg_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                cfg_q[i]  <= cfg_d[i];
                addr_q[i] <= addr_d[i];
            end
            mseccfg_q <= mseccfg_d;
            flush_q   <= flush_d;
        end
    end

    assign csr_pmp_mseccfg_o = mseccfg_q;
    assign pmp_flush_o       = flush_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// tb/tb_ibex_pmp_csr.sv - directed bench for ibex_pmp_csr at granularity 0 and 2
module tb_ibex_pmp_csr;
    import ibex_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         we_a = 1'b0;
    logic         we_b = 1'b0;
    logic [11:0]  addr = '0;
    logic [31:0]  wdata = '0;

    logic [31:0]  rdata_a, rdata_b;
    logic         hit_a, hit_b;
    pmp_cfg_t     cfg_a [4];
    pmp_cfg_t     cfg_b [4];
    logic [33:0]  paddr_a [4];
    logic [33:0]  paddr_b [4];
    pmp_mseccfg_t msec_a, msec_b;
    logic         flush_a, flush_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we_a), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .csr_rdata_o(rdata_a), .csr_hit_o(hit_a),
        .csr_pmp_cfg_o(cfg_a), .csr_pmp_addr_o(paddr_a),
        .csr_pmp_mseccfg_o(msec_a), .pmp_flush_o(flush_a)
    );

    ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we_b), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .csr_rdata_o(rdata_b), .csr_hit_o(hit_b),
        .csr_pmp_cfg_o(cfg_b), .csr_pmp_addr_o(paddr_b),
        .csr_pmp_mseccfg_o(msec_b), .pmp_flush_o(flush_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input bit g2, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we_a  = !g2;
        we_b  = g2;
        @(negedge clk);
        we_a  = 1'b0;
        we_b  = 1'b0;
    endtask

    task automatic check_rd(input bit g2, input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        check_eq(tag, g2 ? rdata_b : rdata_a, exp);
    endtask

    task automatic check_hit(input logic [11:0] a, input logic exp, input string tag);
        addr = a;
        #1;
        check_eq(tag, hit_a, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_rd(0, 12'h3A0, 32'h0, "rst_cfg0");
        check_rd(0, 12'h3B0, 32'h0, "rst_addr0");
        check_rd(0, 12'h747, 32'h0, "rst_msec");
        for (int i = 0; i < 4; i++) check_eq($sformatf("rst_mode%0d", i), cfg_a[i].mode, PMP_MODE_OFF);
        check_eq("rst_flush", flush_a, 1'b0);

        // Hit decode
        check_hit(12'h757, 1'b1, "hit_757");
        check_hit(12'h3BF, 1'b1, "hit_3bf");
        check_hit(12'h3A4, 1'b0, "hit_3a4");
        check_hit(12'h3C0, 1'b0, "hit_3c0");

        // Lock blocks later writes
        csr_write(0, 12'h3A0, 32'h0000_008F);
        check_eq("lock_flush", flush_a, 1'b1);
        check_rd(0, 12'h3A0, 32'h8F, "lock_cfg0");
        check_eq("lock_cfg_o", cfg_a[0].lock, 1'b1);
        csr_write(0, 12'h3B0, 32'h1234);
        check_eq("lock_addr_flush", flush_a, 1'b0);
        check_rd(0, 12'h3B0, 32'h0, "lock_addr0");
        csr_write(0, 12'h3A0, 32'h0);
        check_rd(0, 12'h3A0, 32'h8F, "lock_cfg0_keep");

        csr_write(0, 12'h3A0, 32'h0000_8D8F);
        check_rd(0, 12'h3A0, 32'h8D8F, "tor_cfg");
        csr_write(0, 12'h3B2, 32'h77);
        check_eq("drop_flush_pre", flush_a, 1'b1);

        // Asynchronous reset drops the pending flush and clears state
        rst_n = 1'b0;
        #1;
        check_eq("drop_flush", flush_a, 1'b0);
        check_rd(0, 12'h3B2, 32'h0, "drop_addr2");
        check_rd(0, 12'h3A0, 32'h0, "drop_cfg0");
        @(negedge clk);
        rst_n = 1'b1;

        // RLB set before any lock lets locked TOR neighbour be ignored
        csr_write(0, 12'h747, 32'h4);
        check_rd(0, 12'h747, 32'h4, "rlb_set");
        csr_write(0, 12'h3A0, 32'h0000_8D00);
        check_rd(0, 12'h3A0, 32'h8D00, "rlb_cfg1");
        csr_write(0, 12'h3B0, 32'h100);
        check_rd(0, 12'h3B0, 32'h100, "rlb_addr0");
        check_eq("rlb_addr0_o", paddr_a[0], 34'h400);

        // Reserved R=0 W=1 encoding
        csr_write(0, 12'h3A0, 32'h0000_8D02);
        check_eq("rsv_flush", flush_a, 1'b0);
        check_rd(0, 12'h3A0, 32'h8D00, "rsv_blocked");
        csr_write(0, 12'h747, 32'h5);
        check_rd(0, 12'h747, 32'h5, "mml_set");
        check_eq("mml_o", msec_a.mml, 1'b1);
        csr_write(0, 12'h3A0, 32'h0000_8D02);
        check_rd(0, 12'h3A0, 32'h8D02, "rsv_mml_ok");
        csr_write(0, 12'h747, 32'h4);
        check_rd(0, 12'h747, 32'h5, "mml_sticky");
        csr_write(0, 12'h747, 32'h0);
        check_rd(0, 12'h747, 32'h1, "rlb_clear");

        // MML executable-lock rule
        csr_write(0, 12'h3A0, 32'h0000_8D8C);
        check_rd(0, 12'h3A0, 32'h8D02, "mml_x_block");
        csr_write(0, 12'h3A0, 32'h0000_8D8B);
        check_rd(0, 12'h3A0, 32'h8D8B, "mml_rw_ok");
        csr_write(0, 12'h747, 32'h5);
        check_rd(0, 12'h747, 32'h1, "rlb_stuck");
        csr_write(0, 12'h3B0, 32'h200);
        check_rd(0, 12'h3B0, 32'h100, "tor_guard");
        csr_write(0, 12'h3B2, 32'h55);
        check_rd(0, 12'h3B2, 32'h55, "addr2_ok");

        // Unimplemented registers
        csr_write(0, 12'h3A1, 32'hFFFF_FFFF);
        check_rd(0, 12'h3A1, 32'h0, "cfg1_unimpl");
        csr_write(0, 12'h3B5, 32'h1);
        check_rd(0, 12'h3B5, 32'h0, "addr5_unimpl");
        csr_write(0, 12'h757, 32'hFFFF_FFFF);
        check_rd(0, 12'h757, 32'h0, "msech");

        // Granularity 2
        csr_write(1, 12'h3A0, 32'h18);
        check_rd(1, 12'h3A0, 32'h18, "g2_napot");
        csr_write(1, 12'h3B0, 32'h0);
        check_eq("g2_flush_same", flush_b, 1'b0);
        check_rd(1, 12'h3B0, 32'h1, "g2_napot_rd");
        csr_write(1, 12'h3A0, 32'h08);
        check_eq("g2_flush_tor", flush_b, 1'b1);
        csr_write(1, 12'h3B0, 32'h3);
        check_eq("g2_flush_addr", flush_b, 1'b1);
        check_rd(1, 12'h3B0, 32'h0, "g2_tor_rd");
        check_eq("g2_tor_o", paddr_b[0], 34'h0);
        @(negedge clk);
        check_eq("g2_flush_idle", flush_b, 1'b0);
        csr_write(1, 12'h3A0, 32'h10);
        check_eq("g2_na4_flush", flush_b, 1'b0);
        check_rd(1, 12'h3A0, 32'h08, "g2_na4_keep");
        csr_write(1, 12'h3A0, 32'h11);
        check_eq("g2_na4r_flush", flush_b, 1'b1);
        check_rd(1, 12'h3A0, 32'h09, "g2_na4_r");
        csr_write(1, 12'h3A0, 32'h19);
        check_rd(1, 12'h3B0, 32'h3, "g2_napot_rd3");
        check_eq("g2_napot_o", paddr_b[0], 34'hC);
        check_rd(0, 12'h3A0, 32'h8D8B, "a_untouched");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
